// File: rtl/vga_framebuffer_scanout.sv
// 640x480 monochrome framebuffer: a free-running pixel write port and a VGA scanout.
// The scan runs on every second clk; sync, blank and RGB leave one tick after their counter value.
module vga_framebuffer_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [10:0] x,
    input  logic [10:0] y,
    input  logic        color,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DEPTH   = H_ACTIVE * V_ACTIVE;
    localparam int AW      = $clog2(DEPTH);

    localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_VIS   = 10'(H_ACTIVE);
    localparam logic [9:0]  V_VIS   = 10'(V_ACTIVE);
    localparam logic [9:0]  H_SS    = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]  H_SE    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0]  V_SS    = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  V_SE    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [10:0] X_LIMIT = 11'(H_ACTIVE);
    localparam logic [10:0] Y_LIMIT = 11'(V_ACTIVE);

    // A 640-wide row is 512 + 128, so the row offset is two shifts and an add.
    function automatic logic [18:0] pix_addr(input logic [10:0] col, input logic [10:0] row);
        logic [18:0] c19;
        logic [18:0] r19;
        c19 = 19'(col);
        r19 = 19'(row);
        if (H_ACTIVE == 640) return (r19 << 9) + (r19 << 7) + c19;
        else                 return r19 * 19'(H_ACTIVE) + c19;
    endfunction

    logic        pix_en;
    logic [9:0]  hcnt;
    logic [9:0]  vcnt;
    logic        wr_ok;
    logic        scan_vis;
    logic [18:0] wr_addr;
    logic [18:0] rd_addr;
    logic        rd_data;
    logic        mem [0:DEPTH-1];

    // Range check happens before the address is formed, so off-screen writes never alias.
    assign wr_ok    = wr_en && (x < X_LIMIT) && (y < Y_LIMIT);
    assign wr_addr  = pix_addr(x, y);
    assign scan_vis = (hcnt < H_VIS) && (vcnt < V_VIS);
    assign rd_addr  = pix_addr({1'b0, hcnt}, {1'b0, vcnt});

    // Not reset; a same-address read in the write cycle sees the old bit.
    always_ff @(posedge clk) begin
        if (scan_vis) rd_data <= mem[rd_addr[AW-1:0]];
        if (wr_ok)    mem[wr_addr[AW-1:0]] <= color;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_en      <= 1'b0;
            hcnt        <= '0;
            vcnt        <= '0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            frame_start <= 1'b0;
        end else begin
            pix_en      <= ~pix_en;
            frame_start <= 1'b0;
            if (pix_en) begin
                // rd_data was fetched on the previous clk from the same counter value.
                vga_hs      <= !((hcnt >= H_SS) && (hcnt <= H_SE));
                vga_vs      <= !((vcnt >= V_SS) && (vcnt <= V_SE));
                vga_blank_n <= scan_vis;
                vga_r       <= {8{scan_vis & rd_data}};
                vga_g       <= {8{scan_vis & rd_data}};
                vga_b       <= {8{scan_vis & rd_data}};
                if (hcnt == H_LAST) begin
                    hcnt <= '0;
                    if (vcnt == V_LAST) begin
                        vcnt        <= '0;
                        frame_start <= 1'b1;
                    end else begin
                        vcnt <= vcnt + 10'd1;
                    end
                end else begin
                    hcnt <= hcnt + 10'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_framebuffer_scanout.sv
// Directed bench: a shrunken-timing instance covers whole frames, a full 640x480 instance
// covers line timing, the 640-wide address path and off-screen write dropping.
module tb_vga_framebuffer_scanout;

    // Small instance: line = 24 ticks (48 clk), frame = 13 lines (624 clk)
    localparam int SHA = 16, SHF = 2, SHS = 3, SHB = 3;
    localparam int SVA = 8,  SVF = 1, SVS = 2, SVB = 2;

    localparam int B_HS = 27, B_VS = 26, B_BL = 25, B_R7 = 24, B_FS = 0;
    localparam int S = 0, F = 1;
    localparam int RUN1 = 32030;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_s, we_s, col_s, hs_s, vs_s, bl_s, fs_s;
    logic [10:0] x_s, y_s;
    logic [7:0]  r_s, g_s, b_s;
    logic        rst_f, we_f, col_f, hs_f, vs_f, bl_f, fs_f;
    logic [10:0] x_f, y_f;
    logic [7:0]  r_f, g_f, b_f;

    vga_framebuffer_scanout #(
        .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
    ) dut_s (
        .clk(clk), .reset(rst_s), .wr_en(we_s), .x(x_s), .y(y_s), .color(col_s),
        .vga_hs(hs_s), .vga_vs(vs_s), .vga_blank_n(bl_s),
        .vga_r(r_s), .vga_g(g_s), .vga_b(b_s), .frame_start(fs_s)
    );

    vga_framebuffer_scanout dut_f (
        .clk(clk), .reset(rst_f), .wr_en(we_f), .x(x_f), .y(y_f), .color(col_f),
        .vga_hs(hs_f), .vga_vs(vs_f), .vga_blank_n(bl_f),
        .vga_r(r_f), .vga_g(g_f), .vga_b(b_f), .frame_start(fs_f)
    );

    int total = 0;
    int bad   = 0;

    // Per-clk sample after edge e: {hs, vs, blank_n, r, g, b, frame_start}
    logic [27:0] log_a [0:1][0:RUN1+10];
    logic [9:0]  h2_s, h2_f;
    logic [27:0] rst_val;
    logic [27:0] vis_black;
    int          found;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic wr_s(input int xx, input int yy, input logic c);
        we_s = 1'b1; x_s = 11'(xx); y_s = 11'(yy); col_s = c;
        @(negedge clk);
        we_s = 1'b0;
    endtask

    task automatic wr_f(input int xx, input int yy, input logic c);
        we_f = 1'b1; x_f = 11'(xx); y_f = 11'(yy); col_f = c;
        @(negedge clk);
        we_f = 1'b0;
    endtask

    task automatic capture(input int n);
        for (int e = 1; e <= n; e++) begin
            @(negedge clk);
            log_a[S][e] = {hs_s, vs_s, bl_s, r_s, g_s, b_s, fs_s};
            log_a[F][e] = {hs_f, vs_f, bl_f, r_f, g_f, b_f, fs_f};
            if (e == 2) begin
                h2_s = dut_s.hcnt;
                h2_f = dut_f.hcnt;
            end
        end
    endtask

    function automatic int cnt(input int s, input int b, input logic v, input int lo, input int hi);
        int n = 0;
        for (int e = lo; e <= hi; e++) if (log_a[s][e][b] === v) n++;
        return n;
    endfunction

    function automatic int cnt_rgb(input int s, input int lo, input int hi);
        int n = 0;
        for (int e = lo; e <= hi; e++) if (log_a[s][e][24:1] !== 24'h0) n++;
        return n;
    endfunction

    // First clk in [lo,hi] where bit b changes to v
    function automatic int first_edge(input int s, input int b, input logic v, input int lo, input int hi);
        for (int e = lo; e <= hi; e++)
            if (log_a[s][e][b] === v && log_a[s][e-1][b] === !v) return e;
        return -1;
    endfunction

    initial begin
        rst_val   = {1'b1, 1'b1, 1'b0, 24'h0, 1'b0};
        vis_black = {1'b1, 1'b1, 1'b1, 24'h0, 1'b0};
        rst_s = 1'b0; we_s = 1'b0; x_s = '0; y_s = '0; col_s = 1'b0;
        rst_f = 1'b0; we_f = 1'b0; x_f = '0; y_f = '0; col_f = 1'b0;

        repeat (5) @(negedge clk);
        check("rst_out_s", {hs_s, vs_s, bl_s, r_s, g_s, b_s, fs_s}, rst_val);
        check("rst_out_f", {hs_f, vs_f, bl_f, r_f, g_f, b_f, fs_f}, rst_val);

        // Framebuffer is not reset, so the small one is cleared while reset is held.
        for (int yy = 0; yy < SVA; yy++)
            for (int xx = 0; xx < SHA; xx++) wr_s(xx, yy, 1'b0);
        wr_s(10, 5, 1'b1);
        wr_s(16, 5, 1'b1);   // would land on (0,6) if it aliased
        wr_s(0, 8, 1'b1);    // would land on (0,0) if the address wrapped
        wr_f(0, 0, 1'b0);
        wr_f(0, 6, 1'b0);
        wr_f(9, 20, 1'b0);
        wr_f(11, 20, 1'b0);
        wr_f(10, 20, 1'b1);
        wr_f(640, 5, 1'b1);  // would land on (0,6)
        wr_f(0, 480, 1'b1);
        rst_s = 1'b1;
        rst_f = 1'b1;

        capture(RUN1);

        // ---- small instance: first two frames
        check("s_hcnt_first_tick", 32'(h2_s), 32'd1);
        check("s_e1_still_reset", log_a[S][1], rst_val);
        check("s_e2_pixel00", log_a[S][2], vis_black);
        check("s_pix_10_5_a", 32'(log_a[S][262][24:1]), 32'hFFFFFF);
        check("s_pix_10_5_b", 32'(log_a[S][263][24:1]), 32'hFFFFFF);
        check("s_pix_9_5", 32'(log_a[S][261][24:1]), 32'h0);
        check("s_pix_11_5", 32'(log_a[S][264][24:1]), 32'h0);
        check("s_pix_0_6", 32'(log_a[S][290][24:1]), 32'h0);
        check("s_lit_clk_f1", cnt_rgb(S, 2, 624), 2);
        check("s_lit_clk_f2", cnt_rgb(S, 625, 1248), 2);
        check("s_lit_first_f2", first_edge(S, B_R7, 1'b1, 625, 1248), 886);
        check("s_hs_fall0", first_edge(S, B_HS, 1'b0, 2, 624), 38);
        check("s_hs_fall1", first_edge(S, B_HS, 1'b0, 40, 624), 86);
        check("s_hs_low_clk", cnt(S, B_HS, 1'b0, 1, 48), 6);
        check("s_blank_hi_clk", cnt(S, B_BL, 1'b1, 1, 48), 32);
        check("s_vs_fall", first_edge(S, B_VS, 1'b0, 2, 624), 434);
        check("s_vs_low_clk", cnt(S, B_VS, 1'b0, 1, 624), 96);
        check("s_fs_count", cnt(S, B_FS, 1'b1, 1, 1300), 2);
        check("s_fs_first", first_edge(S, B_FS, 1'b1, 2, 1300), 624);
        check("s_fs_second", first_edge(S, B_FS, 1'b1, 626, 1300), 1248);

        // ---- full-size instance: first line and the 640-wide address path
        check("f_hcnt_first_tick", 32'(h2_f), 32'd1);
        check("f_e2_pixel00", log_a[F][2], vis_black);
        check("f_hs_fall0", first_edge(F, B_HS, 1'b0, 2, 1600), 1314);
        check("f_hs_fall1", first_edge(F, B_HS, 1'b0, 1316, 3200), 2914);
        check("f_hs_low_clk", cnt(F, B_HS, 1'b0, 1, 1600), 192);
        check("f_blank_hi_clk", cnt(F, B_BL, 1'b1, 1, 1600), 1280);
        check("f_pix_0_6", 32'(log_a[F][9602][24:1]), 32'h0);
        check("f_pix_9_20", 32'(log_a[F][32021][24:1]), 32'h0);
        check("f_pix_10_20_a", 32'(log_a[F][32022][24:1]), 32'hFFFFFF);
        check("f_pix_10_20_b", 32'(log_a[F][32023][24:1]), 32'hFFFFFF);
        check("f_pix_11_20", 32'(log_a[F][32024][24:1]), 32'h0);
        check("f_fs_none_early", cnt(F, B_FS, 1'b0, 1, RUN1), RUN1);

        // ---- small instance: reset in mid-frame at line 4 while a write is presented
        found = 0;
        for (int i = 0; i < 2000 && found == 0; i++) begin
            @(negedge clk);
            if (dut_s.vcnt == 10'd4) found = 1;
        end
        check("s_mid_wait_line4", found, 1);
        we_s = 1'b1; x_s = 11'd3; y_s = 11'd2; col_s = 1'b1;
        rst_s = 1'b0;
        #1;
        check("s_mid_rst_immediate", {hs_s, vs_s, bl_s, r_s, g_s, b_s, fs_s}, rst_val);
        @(negedge clk);
        we_s = 1'b0;
        @(negedge clk);
        check("s_mid_rst_held", {hs_s, vs_s, bl_s, r_s, g_s, b_s, fs_s}, rst_val);
        rst_s = 1'b1;

        capture(630);
        check("s2_hcnt_first_tick", 32'(h2_s), 32'd1);
        check("s2_e2_pixel00", log_a[S][2], vis_black);
        check("s2_new_pix_3_2", 32'(log_a[S][104][24:1]), 32'hFFFFFF);
        check("s2_old_pix_10_5", 32'(log_a[S][262][24:1]), 32'hFFFFFF);
        check("s2_lit_clk", cnt_rgb(S, 2, 624), 4);
        check("s2_hs_fall0", first_edge(S, B_HS, 1'b0, 2, 624), 38);
        check("s2_fs_first", first_edge(S, B_FS, 1'b1, 2, 630), 624);
        check("s2_fs_count", cnt(S, B_FS, 1'b1, 1, 630), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_framebuffer_scanout.md
# vga_framebuffer_scanout

Receiving end of the pixel-write stream that the game's display manager produces. The block stores single-bit pixel writes `(x, y, color)` into a 640×480 monochrome framebuffer. Independently, it scans the buffer out as a 640×480@60 Hz VGA signal.

It sits between the display manager and the VGA DAC pins, and gives the game logic a once-per-frame start pulse.

## Interface

Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixel ticks)
- `H_SYNC`, 96, horizontal sync width
- `H_BP`, 48, horizontal back porch
- `V_ACTIVE`, 480, visible lines
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width
- `V_BP`, 33, vertical back porch

Ports:
- `clk`  in  1  system clock, 50 MHz
- `reset`  in  1  asynchronous, active-low reset (asserted at 0)
- `wr_en`  in  1  pixel write strobe, one write per cycle
- `x`  in  11  write column
- `y`  in  11  write row
- `color`  in  1  pixel value, 1 = white, 0 = black
- `vga_hs`  out  1  horizontal sync, active-low
- `vga_vs`  out  1  vertical sync, active-low
- `vga_blank_n`  out  1  high during the visible region
- `vga_r`, `vga_g`, `vga_b`  out  8 each  pixel colour
- `frame_start`  out  1  one-clk pulse at the start of each frame

## Operation

**Write port**
- On each `clk` with `wr_en`=1, `x`<640 and `y`<480: store `color` at address `y*640 + x`.
- Address is 19 bits, computed as `(y<<9)+(y<<7)+x`.
- Writes with `x`≥640 or `y`≥480 are dropped. They must not alias or wrap to another pixel; this matters because the display manager can present off-screen coordinates.
- There is no handshake or backpressure. Writes are accepted in every cycle, including blanking.

**Pixel tick**
- Internal divide-by-2 toggle `pix_en`, reset to 0, toggles every clk.
- A pixel tick is a clk on which `pix_en`=1 (25 MHz).
- All scan state advances only on ticks.

**Scan counters**
- `hcnt` runs 0..799 and wraps to 0.
- `vcnt` increments when `hcnt` wraps and runs 0..524, then wraps to 0.
- Both counters are 10 bits.

**Readout**
- Read port is synchronous, with one clk of latency.
- The read address is driven from the current (`hcnt`, `vcnt`) when `hcnt`<640 and `vcnt`<480; otherwise the address is don't-care.
- Read and write are simultaneous and independent. On a same-address collision the read returns the old data.

**Output stage** (registered on each tick, from the previous tick's counters):
- `vga_hs` = 0 iff 656 ≤ h ≤ 751.
- `vga_vs` = 0 iff 490 ≤ v ≤ 491.
- `vga_blank_n` = 1 iff h<640 and v<480.
- `vga_r`/`vga_g`/`vga_b` = 8'hFF if `vga_blank_n` and the pixel is 1; otherwise 0.

**Frame pulse**
- `frame_start` is 1 for exactly one clk: the tick on which counters wrap from (799, 524) to (0, 0).

**Memory**
- Framebuffer contents are not reset. Memory is inferred block RAM.

## Timing

**Reset values (asynchronous, `reset`=0)**
- `hcnt`=`vcnt`=0, `pix_en`=0.
- `vga_hs`=1, `vga_vs`=1.
- `vga_blank_n`=0, RGB=0.
- `frame_start`=0.

**Write latency**
- A write at clk n is visible to a read issued at clk n+1 or later.

**Scan latency**
- Counter value to pin: 1 tick (2 clk). Sync, blank and RGB are mutually aligned.

**Periods**
- Line: 800 ticks = 1600 clk.
- Frame: 525 lines = 840,000 clk.
- `vga_hs` low for 96 ticks per line; `vga_vs` low for 2 lines per frame.

**Reset mid-frame**
- Outputs go to reset values immediately.
- After release the scan restarts from (0, 0).
- The first `frame_start` occurs at the first full-frame wrap, 840,000 clk after release.

**Simultaneous events**
- A write to the pixel being scanned out shows the old value this frame and the new value next frame.

## Test plan

- **Reset:** hold `reset`=0 for 5 clk → `vga_hs`=`vga_vs`=1, `vga_blank_n`=0, RGB=0, `frame_start`=0. After release, first tick has `hcnt`=1.
- **Pixel write:** write (10, 20)=1, all other pixels 0 → during frame 2, RGB=FF only in the tick where line 20, column 10 is displayed (2 clk after counters reach (10, 20)); 0 elsewhere in the visible region.
- **Out-of-range write:** write x=640, y=5, color=1, then x=0, y=480 → no pixel changes; (0, 6) and (0, 0) stay 0.
- **Horizontal timing:** measure one line → 1600 clk period, `vga_hs` low for 192 clk starting 2 clk after `hcnt`=656. `vga_blank_n` high for 1280 clk.
- **Vertical timing / frame pulse:** run 2 frames → `vga_vs` low for 3200 clk beginning at line 490. `frame_start` pulses exactly once per 840,000 clk, width 1 clk.
- **Reset mid-frame:** assert `reset` at `vcnt`=200 while writing → outputs go to reset values immediately; after release, timing restarts from (0, 0). Previously written pixels still display, since memory is not cleared.
